div_hilo_ctrl: RTL
==================

# div_hilo_ctrl

Multi-cycle controller wrapped around the combinational 32-bit non-restoring unsigned divider. It handles both sides of that divider:
- **Upstream:** latches the register-file operands, converts signed operands to magnitudes, and drives them onto the divider's M/Q inputs.
- **Downstream:** waits a fixed settle window, then sign-corrects the quotient and remainder and writes them to the LO and HI registers.

It pulses `done` at the end. The CPU control unit stalls on `busy`.

## Interface
- `WIDTH`, 32: operand, quotient and remainder width.
- `SETTLE_CYCLES`, 4: clock cycles allowed for the combinational divider to settle (multicycle path), ≥1.
- `clock` in 1: single clock, rising edge.
- `clear` in 1: synchronous, active-high reset.
- `start` in 1: request a divide; sampled only in IDLE.
- `is_signed` in 1: 1 = DIV (signed), 0 = DIVU.
- `dividend` in WIDTH: register-file operand (R-a).
- `divisor` in WIDTH: register-file operand (R-b).
- `div_M` out WIDTH: divisor magnitude, to the divider's M input.
- `div_Q` out WIDTH: dividend magnitude, to the divider's Q input.
- `div_quotient` in WIDTH: quotient from the divider.
- `div_remainder` in WIDTH: remainder from the divider.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `div_by_zero` out 1: last operation had divisor 0; held until the next accepted start.
- `HI` out WIDTH: remainder register.
- `LO` out WIDTH: quotient register.

## Operation
**States:** IDLE, SETTLE, WRITE. A `SETTLE` counter, `cnt`, is ⌈log2(SETTLE_CYCLES)⌉+1 bits.

**IDLE, `start` = 1:**
- Latch the signs and operands.
- `sd` = `is_signed` & dividend[31]; `sv` = `is_signed` & divisor[31].
- `div_Q` <= sd ? −dividend : dividend.
- `div_M` <= sv ? −divisor : divisor.
- Negation is two's complement, modulo 2^WIDTH.
- Set `busy`=1, `done`=0, `div_by_zero`=0.
- If `divisor` == 0: set `div_by_zero`=1 and go to WRITE. Otherwise go to SETTLE with `cnt` = SETTLE_CYCLES−1.

**SETTLE:**
- If `cnt` == 0, go to WRITE; else decrement `cnt`.
- `div_M` and `div_Q` are held constant.

**WRITE, divide by zero:**
- LO <= all ones.
- HI <= the latched dividend (raw, not the magnitude).

**WRITE, normal:**
- LO <= (sd ^ sv) ? −div_quotient : div_quotient.
- HI <= sd ? −div_remainder : div_remainder.
- So the quotient truncates toward zero and the remainder takes the sign of the dividend.

**WRITE, both cases:** `done` <= 1, `busy` <= 0, next state IDLE.

**Other rules:**
- `done` is cleared on the following edge.
- `start` while `busy` is ignored; there is no queuing.
- `start` in the same cycle that `done` is high is accepted, because the FSM is already in IDLE.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0. Wraps, no flag.
- HI/LO change only in WRITE or on `clear`.
- `div_M` and `div_Q` change only on an accepted start or on `clear`.

## Timing
- **Reset values:** every output is 0 (`busy`, `done`, `div_by_zero`, HI, LO, `div_M`, `div_Q`) and the state is IDLE.
- **`clear` priority:** `clear` beats every other input. Mid-operation it aborts with no `done` pulse and no HI/LO write.
- **Normal latency:** counting the start-sampling edge as edge 0, the FSM is in SETTLE after edges 0 … SETTLE_CYCLES−1. WRITE executes at edge SETTLE_CYCLES+1. HI, LO and `done` are visible after that edge.
- **Divide-by-zero latency:** HI/LO/`done` are visible after edge 1.
- **`busy`:** high from after edge 0 until the WRITE edge.
- **Divider outputs:** `div_quotient` and `div_remainder` are sampled only at the WRITE edge.

## Configuration
- **`DIV_SIGNED_EN` defined:** `is_signed` is honoured as described above.
- **`DIV_SIGNED_EN` undefined:** `is_signed` is ignored and treated as 0. The negation logic is not built, all operations are unsigned, and `div_M`/`div_Q` equal the raw operands.

## Test plan
The bench connects a behavioural unsigned divider model. SETTLE_CYCLES = 4 and `DIV_SIGNED_EN` is defined unless noted.
- Unsigned 100/7 → `div_Q`=100, `div_M`=7; LO=14, HI=2; `done` seen after edge 5; `busy` high after edges 0–4.
- Signed −7/2 (0xFFFFFFF9/2) → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Signed 7/−2 → LO=0xFFFFFFFD, HI=1.
- 5/0 → `div_by_zero`=1, LO=0xFFFFFFFF, HI=5, `done` after edge 1. A following 9/3 clears `div_by_zero`.
- Signed 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- `start` pulsed again at edge 2 with different operands → ignored; result matches the first operands. `start` asserted while `done`=1 → accepted.
- `clear` at edge 3 of an operation → IDLE, all outputs 0, no `done` pulse. Rebuild without `DIV_SIGNED_EN`: 0xFFFFFFF9/2, `is_signed`=1 → LO=0x7FFFFFFC, HI=1.

Source files
------------

// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl: multi-cycle controller around a combinational unsigned divider.
// It latches the operands and drives their magnitudes onto the divider's M/Q inputs.
// It then waits a fixed settle window and writes the sign-corrected quotient to LO
// and the sign-corrected remainder to HI.
// Optional feature macro: DIV_SIGNED_EN (signed DIV support). When it is undefined,
// is_signed is ignored and every operation is unsigned.
//
// Handshake: start is sampled only while the FSM is in IDLE (busy low). A start
// seen while busy is dropped, not queued. done is a one-cycle pulse at the end of
// every operation that was not aborted by clear.
module div_hilo_ctrl #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] div_M,
  output logic [WIDTH-1:0] div_Q,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(SETTLE_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_div_m;
  logic [WIDTH-1:0] r_div_q;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;

  logic             w_is_zero;
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_m_mag;
  logic [WIDTH-1:0] w_lo_fix;
  logic [WIDTH-1:0] w_hi_fix;

  assign w_is_zero = (divisor == '0);

`ifdef DIV_SIGNED_EN
  // Operand signs are latched at start so the write-back correction uses the
  // signs of the operation in flight, not whatever the register file shows now.
  logic r_sd;
  logic r_sv;
  logic w_sd;
  logic w_sv;

  assign w_sd     = is_signed & dividend[WIDTH-1];
  assign w_sv     = is_signed & divisor[WIDTH-1];
  assign w_q_mag  = w_sd ? (~dividend + 1'b1) : dividend;
  assign w_m_mag  = w_sv ? (~divisor + 1'b1) : divisor;
  // Quotient is negative when exactly one operand is negative; the remainder
  // follows the dividend's sign (truncation toward zero).
  assign w_lo_fix = (r_sd ^ r_sv) ? (~div_quotient + 1'b1) : div_quotient;
  assign w_hi_fix = r_sd ? (~div_remainder + 1'b1) : div_remainder;
`else
  logic w_unused_signed;

  assign w_unused_signed = is_signed;
  assign w_q_mag         = dividend;
  assign w_m_mag         = divisor;
  assign w_lo_fix        = div_quotient;
  assign w_hi_fix        = div_remainder;
`endif

  // Control FSM: IDLE -> SETTLE (count down the multicycle window) -> WRITE -> IDLE.
  // A zero divisor skips SETTLE, because the divider's result is not used.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_div_m    <= '0;
      r_div_q    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dz       <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_sd       <= 1'b0;
      r_sv       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dividend <= dividend;
            r_div_q    <= w_q_mag;
            r_div_m    <= w_m_mag;
`ifdef DIV_SIGNED_EN
            r_sd       <= w_sd;
            r_sv       <= w_sv;
`endif
            r_busy     <= 1'b1;
            r_dz       <= w_is_zero;
            if (w_is_zero) begin
              r_state <= S_WRITE;
            end else begin
              r_state <= S_SETTLE;
              r_cnt   <= CW'(SETTLE_CYCLES - 1);
            end
          end
        end
        S_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= S_WRITE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WRITE: begin
          if (r_dz) begin
            r_lo <= '1;
            r_hi <= r_dividend;
          end else begin
            r_lo <= w_lo_fix;
            r_hi <= w_hi_fix;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign div_M       = r_div_m;
  assign div_Q       = r_div_q;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dz;
  assign HI          = r_hi;
  assign LO          = r_lo;
  assign o_dbg_state = r_state;

endmodule
